// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Computes a - b - bin over 32 bits, SLICE_W bits per clock, LSB slice
//   first, with the borrow carried from one slice to the next. The result
//   is offered on a valid/ready output and held until it is consumed.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for operands, in_ready = 1
//   CALC  | one slice per edge, 32/SLICE_W edges in total
//   DONE  | result valid, held until out_ready
//
// Ports
//   clk       : clock, rising edge
//   rst       : synchronous reset, active high
//   in_valid  : operands present on a/b/bin
//   in_ready  : block can accept operands (IDLE only)
//   a, b, bin : minuend, subtrahend, borrow in
//   out_valid : diff/bout/ovf valid (DONE only)
//   out_ready : consumer accepts result
//   diff      : a - b - bin modulo 2^32
//   bout      : unsigned borrow out
//   ovf       : two's-complement signed overflow
module serial_subtractor #(
   parameter int SLICE_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        bin,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] diff,
   output logic        bout,
   output logic        ovf
);

   localparam int NSLICE = 32 / SLICE_W;
   localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t             r_state;
   state_t             w_next;
   logic [31:0]        r_a;
   logic [31:0]        r_b;
   logic [31:0]        r_diff;
   logic               r_borrow;
   logic               r_ovf;
   logic [CNT_W-1:0]   r_cnt;

   logic               w_accept;
   logic               w_last;
   logic               w_in_ready;
   logic               w_out_valid;
   logic [SLICE_W-1:0] w_a_slice;
   logic [SLICE_W-1:0] w_b_slice;
   logic [SLICE_W:0]   w_sub;

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            w_in_ready = 1'b1;
            if (in_valid) begin
               w_accept = 1'b1;
               w_next   = CALC;
            end
         end
         CALC: begin
            if (w_last) w_next = DONE;
         end
         DONE: begin
            w_out_valid = 1'b1;
            if (out_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   assign w_last    = (r_cnt == LAST);
   assign w_a_slice = r_a[r_cnt*SLICE_W +: SLICE_W];
   assign w_b_slice = r_b[r_cnt*SLICE_W +: SLICE_W];

   // One extra bit on the left: it comes out as 1 exactly when the slice
   // subtraction went negative, i.e. the borrow into the next slice.
   assign w_sub = {1'b0, w_a_slice} - {1'b0, w_b_slice} - {{SLICE_W{1'b0}}, r_borrow};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
         r_ovf    <= 1'b0;
         r_cnt    <= '0;
      end else if (w_accept) begin
         r_a      <= a;
         r_b      <= b;
         r_borrow <= bin;
         r_ovf    <= 1'b0;
         r_cnt    <= '0;
      end else if (r_state == CALC) begin
         r_diff[r_cnt*SLICE_W +: SLICE_W] <= w_sub[SLICE_W-1:0];
         r_borrow <= w_sub[SLICE_W];
         if (w_last) begin
            // On the top slice w_sub[SLICE_W-1] is diff[31].
            r_ovf <= (r_a[31] ^ r_b[31]) & (w_sub[SLICE_W-1] ^ r_a[31]);
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = w_out_valid;
   assign diff      = r_diff;
   assign bout      = r_borrow;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        bin;
      logic [31:0] diff;
      logic        bout;
      logic        ovf;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        bin = 1'b0;
   logic        in_ready, out_valid, bout, ovf;
   logic [31:0] diff;

   logic        iv1 = 1'b0, or1 = 1'b0, ir1, ov1, bo1, of1;
   logic [31:0] d1;
   logic        iv32 = 1'b0, or32 = 1'b0, ir32, ov32, bo32, of32;
   logic [31:0] d32;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.SLICE_W(8)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .bout(bout), .ovf(ovf));

   serial_subtractor #(.SLICE_W(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
      .a(a), .b(b), .bin(bin), .out_valid(ov1), .out_ready(or1),
      .diff(d1), .bout(bo1), .ovf(of1));

   serial_subtractor #(.SLICE_W(32)) u_dut32 (
      .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
      .a(a), .b(b), .bin(bin), .out_valid(ov32), .out_ready(or32),
      .diff(d32), .bout(bo32), .ovf(of32));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Called #1 after the accept edge; counts edges until out_valid rises.
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int lat;
      @(negedge clk);
      a = v.a; b = v.b; bin = v.bin; in_valid = 1'b1; out_ready = 1'b0;
      chk({tag, " in_ready_before"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = ~v.a; b = v.b ^ 32'h5A5A_5A5A; bin = ~v.bin;
      wait_valid(lat);
      chk({tag, " latency"}, 32'(lat), 32'd4);
      chk({tag, " diff"}, diff, v.diff);
      chk({tag, " bout"}, 32'(bout), 32'(v.bout));
      chk({tag, " ovf"}, 32'(ovf), 32'(v.ovf));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, " out_valid_after_consume"}, 32'(out_valid), 32'd0);
      chk({tag, " in_ready_after_consume"}, 32'(in_ready), 32'd1);
   endtask

   vec_t vecs[10];

   initial begin
      int lat, lat1, lat32;

      vecs[0] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
      vecs[1] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
      vecs[2] = '{32'hFFFF_FFFC, 32'hFFFF_FFF8, 1'b0, 32'h0000_0004, 1'b0, 1'b0};
      vecs[3] = '{32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
      vecs[4] = '{32'h0000_0007, 32'h0000_000A, 1'b0, 32'hFFFF_FFFD, 1'b1, 1'b0};
      vecs[5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1};
      vecs[6] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
      vecs[7] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
      vecs[8] = '{32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0};
      vecs[9] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst in_ready", 32'(in_ready), 32'd1);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst diff", diff, 32'd0);
      chk("rst bout", 32'(bout), 32'd0);
      chk("rst ovf", 32'(ovf), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Result held under backpressure while a second request waits.
      @(negedge clk);
      a = 32'h5; b = 32'h3; bin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      a = 32'hAAAA_0000; b = 32'h1; bin = 1'b0;
      chk("bp in_ready_calc", 32'(in_ready), 32'd0);
      wait_valid(lat);
      chk("bp latency", 32'(lat), 32'd4);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("bp diff_hold%0d", k), diff, 32'h1);
         chk($sformatf("bp out_valid_hold%0d", k), 32'(out_valid), 32'd1);
         chk($sformatf("bp in_ready_hold%0d", k), 32'(in_ready), 32'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp out_valid_consumed", 32'(out_valid), 32'd0);
      chk("bp not_accepted_at_consume", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp accepted_next", 32'(in_ready), 32'd0);
      wait_valid(lat);
      chk("bp2 latency", 32'(lat), 32'd4);
      chk("bp2 diff", diff, 32'hAAA9_FFFF);
      chk("bp2 bout", 32'(bout), 32'd0);
      chk("bp2 ovf", 32'(ovf), 32'd0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Reset on the second CALC edge discards the operation.
      @(negedge clk);
      a = 32'hFFFF_0000; b = 32'h0000_FFFF; bin = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rstcalc out_valid", 32'(out_valid), 32'd0);
      chk("rstcalc in_ready", 32'(in_ready), 32'd1);
      chk("rstcalc diff", diff, 32'd0);
      chk("rstcalc bout", 32'(bout), 32'd0);
      run_vec(vecs[4], "after_rst");

      // SLICE_W = 1 and 32 builds on the overflow vector.
      @(negedge clk);
      a = 32'h8000_0000; b = 32'h1; bin = 1'b0; iv1 = 1'b1; iv32 = 1'b1;
      @(posedge clk); #1;
      iv1 = 1'b0; iv32 = 1'b0;
      lat1 = -1; lat32 = -1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (ov1 && lat1 < 0) lat1 = c;
         if (ov32 && lat32 < 0) lat32 = c;
      end
      chk("w1 latency", 32'(lat1), 32'd32);
      chk("w1 diff", d1, 32'h7FFF_FFFF);
      chk("w1 bout", 32'(bo1), 32'd0);
      chk("w1 ovf", 32'(of1), 32'd1);
      chk("w32 latency", 32'(lat32), 32'd1);
      chk("w32 diff", d32, 32'h7FFF_FFFF);
      chk("w32 bout", 32'(bo32), 32'd0);
      chk("w32 ovf", 32'(of32), 32'd1);
      or1 = 1'b1; or32 = 1'b1;
      @(posedge clk); #1;
      or1 = 1'b0; or32 = 1'b0;
      chk("w1 in_ready_after", 32'(ir1), 32'd1);
      chk("w32 in_ready_after", 32'(ir32), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
